// File: rtl/seq_detector_if.sv
// Bus between the serial front end / register block and seq_detector.
// The master drives the stream and configuration; the slave returns the match status.
interface seq_detector_if #(
  parameter int unsigned LEN   = 8,
  parameter int unsigned CNT_W = 8
);
  logic             a;
  logic             a_valid;
  logic [LEN-1:0]   seq;
  logic [LEN-1:0]   mask;
  logic             cfg_load;
  logic             overlap;
  logic             clr;
  logic             valid;
  logic             armed;
  logic [CNT_W-1:0] match_count;

  modport master (
    output a, a_valid, seq, mask, cfg_load, overlap, clr,
    input  valid, armed, match_count
  );

  modport slave (
    input  a, a_valid, seq, mask, cfg_load, overlap, clr,
    output valid, armed, match_count
  );
endinterface

// File: rtl/seq_detector.sv
// Masked serial pattern detector with overlapping/non-overlapping modes,
// a registered one-cycle match pulse and a saturating match counter.
module seq_detector #(
  parameter int unsigned LEN   = 8,
  parameter int unsigned CNT_W = 8
) (
  input logic           clk,
  input logic           reset_n,
  seq_detector_if.slave bus
);
  localparam int unsigned FillW = $clog2(LEN + 1);

  typedef enum logic [0:0] {StFill, StArmed} state_e;

  state_e           state_q, state_d;
  logic [LEN-1:0]   sr_q, sr_d;
  logic [LEN-1:0]   pat_q, pat_d;
  logic [LEN-1:0]   msk_q, msk_d;
  logic [FillW-1:0] fill_q, fill_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [LEN-1:0]   win;
  logic             full;
  logic             hit;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StFill;
      sr_q    <= '0;
      pat_q   <= '0;
      msk_q   <= '1;
      fill_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      pat_q   <= pat_d;
      msk_q   <= msk_d;
      fill_q  <= fill_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  // Window as it will look once the current sample is shifted in.
  assign win  = {sr_q[LEN-2:0], bus.a};
  assign full = (state_q == StArmed) || (fill_q == FillW'(LEN - 1));
  assign hit  = bus.a_valid && full && (((win ^ pat_q) & msk_q) == '0);

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    pat_d   = pat_q;
    msk_d   = msk_q;
    fill_d  = fill_q;
    valid_d = 1'b0;
    cnt_d   = cnt_q;

    if (bus.cfg_load) begin
      pat_d   = bus.seq;
      msk_d   = bus.mask;
      sr_d    = '0;
      fill_d  = '0;
      state_d = StFill;
    end else if (bus.a_valid) begin
      sr_d = win;
      if (state_q == StFill) begin
        fill_d = fill_q + FillW'(1);
        if (fill_q == FillW'(LEN - 1)) begin
          state_d = StArmed;
        end
      end
      if (hit) begin
        valid_d = 1'b1;
        if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (!bus.overlap) begin
          fill_d  = '0;
          state_d = StFill;
        end
      end
    end

    // Clear beats a coincident increment; the pulse itself is unaffected.
    if (bus.clr) begin
      cnt_d = '0;
    end
  end

  always_comb begin
    bus.valid       = valid_q;
    bus.armed       = (state_q == StArmed);
    bus.match_count = cnt_q;
  end
endmodule

// File: tb/tb_seq_detector.sv
// Directed bench for seq_detector (LEN=4, CNT_W=2) with a queue of expected
// {valid, armed, match_count} entries pushed per driven step and popped after the edge.
module tb_seq_detector;
  localparam int unsigned LEN   = 4;
  localparam int unsigned CNT_W = 2;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  logic [3:0] exp_q[$];

  seq_detector_if #(.LEN(LEN), .CNT_W(CNT_W)) bus ();

  seq_detector #(.LEN(LEN), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [CNT_W-1:0] obs, input logic [CNT_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, queue the expectation, then compare #1 after the edge.
  task automatic step(input logic ai, input logic avi, input logic ve, input logic ae,
                      input logic [CNT_W-1:0] ce, input string tag);
    logic [3:0] e;
    bus.a       = ai;
    bus.a_valid = avi;
    exp_q.push_back({ve, ae, ce});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({tag, ".valid"}, CNT_W'(bus.valid), CNT_W'(e[3]));
    check({tag, ".armed"}, CNT_W'(bus.armed), CNT_W'(e[2]));
    check({tag, ".count"}, bus.match_count, e[1:0]);
    bus.cfg_load = 1'b0;
    bus.clr      = 1'b0;
  endtask

  task automatic load(input logic [LEN-1:0] s, input logic [LEN-1:0] m, input logic ai,
                      input logic avi, input logic [CNT_W-1:0] ce, input string tag);
    bus.seq      = s;
    bus.mask     = m;
    bus.cfg_load = 1'b1;
    step(ai, avi, 1'b0, 1'b0, ce, tag);
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    bus.a        = 1'b0;
    bus.a_valid  = 1'b0;
    bus.seq      = '0;
    bus.mask     = '0;
    bus.cfg_load = 1'b0;
    bus.overlap  = 1'b1;
    bus.clr      = 1'b0;
    reset_n      = 1'b0;
    #2;

    // Reset, with load/clr/sample also asserted: reset wins.
    bus.cfg_load = 1'b1;
    bus.clr      = 1'b1;
    bus.mask     = 4'b0000;
    step(1, 1, 0, 0, 0, "rst");
    reset_n = 1'b1;

    // Reset pattern 0000 / mask 1111, zero stream, overlapping.
    step(0, 1, 0, 0, 0, "z1");
    step(0, 1, 0, 0, 0, "z2");
    step(0, 1, 0, 0, 0, "z3");
    step(0, 1, 1, 1, 1, "z4");
    step(0, 1, 1, 1, 2, "z5");
    step(0, 1, 1, 1, 3, "z6");
    step(0, 1, 1, 1, 3, "z7_sat");
    step(1, 1, 0, 1, 3, "z8_nomatch");
    bus.clr = 1'b1;
    step(0, 0, 0, 1, 0, "z_clr");

    // 1011 overlapping: hits on samples 4 and 7.
    load(4'b1011, 4'b1111, 0, 0, 0, "ov_load");
    step(1, 1, 0, 0, 0, "ov1");
    step(0, 1, 0, 0, 0, "ov2");
    step(1, 1, 0, 0, 0, "ov3");
    step(1, 1, 1, 1, 1, "ov4");
    step(0, 1, 0, 1, 1, "ov5");
    step(1, 1, 0, 1, 1, "ov6");
    step(1, 1, 1, 1, 2, "ov7");
    bus.clr = 1'b1;
    step(0, 0, 0, 1, 0, "ov_clr");

    // Same stream non-overlapping: one hit, then a full refill is needed.
    bus.overlap = 1'b0;
    load(4'b1011, 4'b1111, 0, 0, 0, "no_load");
    step(1, 1, 0, 0, 0, "no1");
    step(0, 1, 0, 0, 0, "no2");
    step(1, 1, 0, 0, 0, "no3");
    step(1, 1, 1, 0, 1, "no4");
    step(0, 1, 0, 0, 1, "no5");
    step(1, 1, 0, 0, 1, "no6");
    step(1, 1, 0, 0, 1, "no7");
    step(1, 1, 0, 1, 1, "no8_arm");
    bus.overlap = 1'b1;
    bus.clr     = 1'b1;
    step(0, 0, 0, 1, 0, "no_clr");

    // Masked 1xx1 with bubbles carrying misleading data.
    load(4'b1001, 4'b1001, 0, 0, 0, "bb_load");
    step(1, 1, 0, 0, 0, "bb1");
    step(0, 0, 0, 0, 0, "bb_gap1");
    step(1, 1, 0, 0, 0, "bb2");
    step(0, 0, 0, 0, 0, "bb_gap2");
    step(0, 1, 0, 0, 0, "bb3");
    step(0, 0, 0, 0, 0, "bb_gap3");
    step(1, 1, 1, 1, 1, "bb4");
    step(1, 0, 0, 1, 1, "bb_gap4");
    bus.clr = 1'b1;
    step(0, 0, 0, 1, 0, "bb_clr");

    // All-don't-care mask: every full window matches; saturate then clear on a hit.
    load(4'b0101, 4'b0000, 0, 0, 0, "sat_load");
    step(1, 1, 0, 0, 0, "sat1");
    step(0, 1, 0, 0, 0, "sat2");
    step(1, 1, 0, 0, 0, "sat3");
    step(1, 1, 1, 1, 1, "sat4");
    step(0, 1, 1, 1, 2, "sat5");
    step(0, 1, 1, 1, 3, "sat6");
    step(1, 1, 1, 1, 3, "sat7");
    step(0, 1, 1, 1, 3, "sat8");
    bus.clr = 1'b1;
    step(1, 1, 1, 1, 0, "sat9_clr");
    step(1, 1, 1, 1, 1, "sat10");

    // Mid-stream reset discards the partial window and the count.
    load(4'b1011, 4'b1111, 0, 0, 1, "mr_load");
    step(1, 1, 0, 0, 1, "mr1");
    step(0, 1, 0, 0, 1, "mr2");
    step(1, 1, 0, 0, 1, "mr3");
    reset_n = 1'b0;
    step(1, 1, 0, 0, 0, "mr_rst");
    reset_n = 1'b1;
    step(1, 1, 0, 0, 0, "mr4");

    // Load mid-fill restarts the fill; the coincident sample is dropped.
    load(4'b1011, 4'b1111, 0, 0, 0, "ml_load1");
    step(1, 1, 0, 0, 0, "ml1");
    step(0, 1, 0, 0, 0, "ml2");
    load(4'b1011, 4'b1111, 1, 1, 0, "ml_load2");
    step(1, 1, 0, 0, 0, "ml3");
    step(0, 1, 0, 0, 0, "ml4");
    step(1, 1, 0, 0, 0, "ml5");
    step(1, 1, 1, 1, 1, "ml6");
    step(0, 0, 0, 1, 1, "ml_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seq_detector.md
# seq_detector

Parametrised serial sequence detector: successor to the fixed 4-bit detector. Shifts in a strobed serial bit stream, compares the most recent LEN bits against a runtime-loaded pattern under a per-bit care mask, and emits a one-cycle match pulse. Supports overlapping and non-overlapping detection and keeps a saturating match counter. Sits between a serial front end and the status/control register block.

## Interface
- LEN, 8: pattern length in bits, legal 2..32.
- CNT_W, 8: match counter width, legal 1..16.

- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- a  in  1  serial data bit.
- a_valid  in  1  sample strobe; a is consumed only on edges where a_valid=1.
- seq  in  LEN  pattern; seq[LEN-1] = oldest bit, seq[0] = newest bit.
- mask  in  LEN  care mask; 1 = compare bit, 0 = don't care.
- cfg_load  in  1  capture seq/mask into internal pattern registers.
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- clr  in  1  clear match counter.
- valid  out  1  one-cycle match pulse (registered).
- armed  out  1  window holds LEN fresh samples (state ARMED).
- match_count  out  CNT_W  saturating count of matches.

## Operation
- Internal: shift register sr[LEN-1:0], pattern register pat, mask register msk, fill counter fill (0..LEN), state {FILL, ARMED}, counter.
- Shift: on edge with a_valid=1, sr <= {sr[LEN-2:0], a}. a_valid=0 edges leave sr and fill unchanged (bubbles do not shift).
- FILL: each accepted sample increments fill; when the sample that makes fill reach LEN is accepted, state -> ARMED on that edge.
- Match condition at an accepted-sample edge: next window w = {sr[LEN-2:0], a}; match = ((w ^ pat) & msk) == 0 AND the window is full after this sample (state ARMED, or FILL with fill = LEN-1).
- On match: valid <= 1 for one cycle; counter increments, holding at 2^CNT_W-1 (no wrap).
- overlap=1: stay ARMED after match; next match can share bits.
- overlap=0: on match, fill <= 0 and state -> FILL; the next match needs LEN new samples. sr contents are irrelevant until refilled.
- overlap is sampled at the match edge only; changing it mid-stream affects only subsequent matches.
- cfg_load=1: pat <= seq, msk <= mask, sr <= 0, fill <= 0, state -> FILL, valid <= 0. Counter untouched. A simultaneous a_valid sample is discarded (load wins).
- clr=1: counter <= 0; if a match occurs on the same edge, clr wins (counter = 0) but valid still pulses.
- msk all zeros: every full window matches.
- armed = (state == ARMED).

## Timing
- Reset (reset_n=0 at a rising edge): sr=0, pat=0, msk=all ones, fill=0, state=FILL, valid=0, armed=0, match_count=0. Reset overrides cfg_load, clr, a_valid. Reset mid-stream discards partial window; LEN new samples needed after release.
- Latency: valid high in the cycle immediately after the edge that accepts the completing bit; exactly one cycle wide; back-to-back pulses possible (overlap=1, a match every sample).
- match_count updates on the same edge valid rises.
- armed rises on the edge accepting the LEN-th sample; falls on the match edge when overlap=0, on cfg_load, on reset.
- New pattern from cfg_load takes effect for the comparison at the first edge after the load edge.

## Test plan
- LEN=4, load seq=1011 mask=1111, overlap=1, stream 1,0,1,1,0,1,1 (a_valid=1 every cycle) -> valid pulses after samples 4 and 7; match_count=2.
- Same config, overlap=0, same stream -> single pulse after sample 4; armed drops then; match_count=1.
- LEN=4, seq=0000 after reset, stream of 0s -> no valid for samples 1-3, first pulse after sample 4, then every sample (overlap=1).
- LEN=4, seq=1001 mask=1001, stream 1,1,0,1 with a_valid=0 bubbles between each sample -> one pulse after the 4th accepted sample; bubbles cause no shift.
- CNT_W=2, 5 matches, then clr concurrent with a 6th match -> count reads 3 after 5th match, 0 after clr edge, valid still pulses.
- Feed 1,0,1 then reset_n=0 one cycle, then 1 -> no valid; armed=0; match needs 4 fresh samples; cfg_load mid-fill similarly restarts fill.
